// File: rtl/panel_input_conditioner_pkg.sv
// panel_input_conditioner shared types and helpers.
// Per-channel hold state and constant width helpers.
package panel_input_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_HELD_WAIT   = 2'd1,
        ST_HELD_REPEAT = 2'd2
    } chan_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of a counter holding 0..n inclusive, never below one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/panel_input_conditioner_if.sv
// Pin-side and conditioned-side bundle for the panel input conditioner.
// master drives the pins, slave is the conditioner.
interface panel_input_conditioner_if #(
    parameter int N_CH = 8
);
    logic [N_CH-1:0] raw_i;
    logic [N_CH-1:0] level_o;
    logic [N_CH-1:0] press_o;
    logic [N_CH-1:0] release_o;
    logic [N_CH-1:0] strobe_o;
    logic            any_active_o;

    modport master (
        output raw_i,
        input  level_o,
        input  press_o,
        input  release_o,
        input  strobe_o,
        input  any_active_o
    );

    modport slave (
        input  raw_i,
        output level_o,
        output press_o,
        output release_o,
        output strobe_o,
        output any_active_o
    );
endinterface

// File: rtl/panel_input_conditioner_channel.sv
// One conditioned input: synchroniser, debounce counter,
// press/release detection and auto-repeat state machine.
module panel_input_channel
    import panel_input_conditioner_pkg::*;
#(
    parameter int DEB_TICKS       = 100,
    parameter int REP_DELAY_TICKS = 5000,
    parameter int REP_RATE_TICKS  = 1000,
    parameter bit INVERT          = 1'b0,
    parameter bit REPEAT          = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic strobe_o
);
    localparam int CW = cnt_width(DEB_TICKS);
    localparam int RW = cnt_width(max_int(REP_DELAY_TICKS, REP_RATE_TICKS));

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_TICKS - 1);
    localparam logic [RW-1:0] DLY_LAST  = RW'(REP_DELAY_TICKS - 1);
    localparam logic [RW-1:0] RATE_LAST = RW'(REP_RATE_TICKS - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          s;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          level_d;
    logic          rise;
    logic          fall;
    chan_state_e   state_q;
    logic [RW-1:0] rcnt_q;
    logic          press_q;
    logic          release_q;
    logic          strobe_q;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q ^ INVERT;

    // Debounce: any agreeing cycle clears, disagreeing ticks count up.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == DEB_LAST) begin
                level_d = s;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    // Hold/repeat state machine with registered pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RELEASED;
            rcnt_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            strobe_q  <= 1'b0;
            unique case (state_q)
                ST_RELEASED: begin
                    if (rise) begin
                        state_q  <= ST_HELD_WAIT;
                        rcnt_q   <= '0;
                        press_q  <= 1'b1;
                        strobe_q <= 1'b1;
                    end
                end
                ST_HELD_WAIT: begin
                    if (fall) begin
                        state_q   <= ST_RELEASED;
                        rcnt_q    <= '0;
                        release_q <= 1'b1;
                    end else if (tick_i) begin
                        if (rcnt_q != DLY_LAST) begin
                            rcnt_q <= rcnt_q + RW'(1);
                        end else if (REPEAT) begin
                            strobe_q <= 1'b1;
                            rcnt_q   <= '0;
                            state_q  <= ST_HELD_REPEAT;
                        end
                    end
                end
                ST_HELD_REPEAT: begin
                    if (fall) begin
                        state_q   <= ST_RELEASED;
                        rcnt_q    <= '0;
                        release_q <= 1'b1;
                    end else if (tick_i) begin
                        if (rcnt_q == RATE_LAST) begin
                            strobe_q <= 1'b1;
                            rcnt_q   <= '0;
                        end else begin
                            rcnt_q <= rcnt_q + RW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_RELEASED;
                    rcnt_q  <= '0;
                end
            endcase
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign strobe_o  = strobe_q;

endmodule

// File: rtl/panel_input_conditioner.sv
// Front-panel input conditioner: shared sample-tick prescaler
// feeding N_CH independent debounce/repeat channels.
module panel_input_conditioner
    import panel_input_conditioner_pkg::*;
#(
    parameter int              N_CH            = 8,
    parameter int              TICK_DIV        = 2500,
    parameter int              DEB_TICKS       = 100,
    parameter int              REP_DELAY_TICKS = 5000,
    parameter int              REP_RATE_TICKS  = 1000,
    parameter logic [N_CH-1:0] INVERT_MASK     = '0,
    parameter logic [N_CH-1:0] REPEAT_MASK     = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    panel_input_conditioner_if.slave pins
);
    localparam int PW = cnt_width(TICK_DIV - 1);
    localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]   pre_q;
    logic [PW-1:0]   pre_d;
    logic            tick;
    logic [N_CH-1:0] lvl;
    logic [N_CH-1:0] prs;
    logic [N_CH-1:0] rel;
    logic [N_CH-1:0] stb;

    assign tick  = (pre_q == DIV_LAST);
    assign pre_d = tick ? '0 : pre_q + PW'(1);

    // Free-running sample prescaler, restarted by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        panel_input_channel #(
            .DEB_TICKS       (DEB_TICKS),
            .REP_DELAY_TICKS (REP_DELAY_TICKS),
            .REP_RATE_TICKS  (REP_RATE_TICKS),
            .INVERT          (INVERT_MASK[i]),
            .REPEAT          (REPEAT_MASK[i])
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .tick_i    (tick),
            .raw_i     (pins.raw_i[i]),
            .level_o   (lvl[i]),
            .press_o   (prs[i]),
            .release_o (rel[i]),
            .strobe_o  (stb[i])
        );
    end

    assign pins.level_o      = lvl;
    assign pins.press_o      = prs;
    assign pins.release_o    = rel;
    assign pins.strobe_o     = stb;
    assign pins.any_active_o = |lvl;

endmodule

// File: tb/tb_panel_input_conditioner.sv
// Self-checking bench for panel_input_conditioner: directed scenarios
// plus random pin activity against a behavioural model.
module tb_panel_input_conditioner;
    localparam int N    = 4;
    localparam int TD   = 4;
    localparam int DEB  = 3;
    localparam int DLY  = 5;
    localparam int RATE = 2;
    localparam logic [N-1:0] INV = 4'b1000;
    localparam logic [N-1:0] REP = 4'b0010;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_STB   = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    int tcyc = 0;

    panel_input_conditioner_if #(.N_CH(N)) bus();

    panel_input_conditioner #(
        .N_CH            (N),
        .TICK_DIV        (TD),
        .DEB_TICKS       (DEB),
        .REP_DELAY_TICKS (DLY),
        .REP_RATE_TICKS  (RATE),
        .INVERT_MASK     (INV),
        .REPEAT_MASK     (REP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pins  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tcyc <= tcyc + 1;

    // Behavioural model: level changes after DEB disagreeing ticks with
    // no agreeing cycle between; repeats fall at fixed cycle offsets
    // from the press (DLY*TD, then every RATE*TD).
    logic [N-1:0] m_s1, m_s2, m_lvl, m_press, m_rel, m_stb, m_s;
    int  m_n[N];
    int  m_since[N];
    bit  m_held[N];
    bit  m_ev;
    bit  m_tk;
    int  m_cyc;

    always @(posedge clk) begin
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0;
            m_press = '0; m_rel = '0; m_stb = '0;
            m_cyc = 0;
            for (int i = 0; i < N; i++) begin
                m_n[i] = 0; m_since[i] = 0; m_held[i] = 0;
            end
        end else begin
            m_s  = m_s2 ^ INV;
            m_tk = (m_cyc % TD) == (TD - 1);
            m_press = '0; m_rel = '0; m_stb = '0;
            for (int i = 0; i < N; i++) begin
                m_ev = 0;
                if (m_s[i] == m_lvl[i]) begin
                    m_n[i] = 0;
                end else if (m_tk) begin
                    m_n[i] = m_n[i] + 1;
                    if (m_n[i] == DEB) begin
                        m_n[i] = 0;
                        m_lvl[i] = m_s[i];
                        m_ev = 1;
                        if (m_s[i]) begin
                            m_press[i] = 1'b1;
                            m_stb[i] = 1'b1;
                            m_held[i] = 1;
                            m_since[i] = 0;
                        end else begin
                            m_rel[i] = 1'b1;
                            m_held[i] = 0;
                        end
                    end
                end
                if (m_held[i] && !m_ev) begin
                    m_since[i] = m_since[i] + 1;
                    if (REP[i] && m_since[i] >= DLY * TD &&
                        ((m_since[i] - DLY * TD) % (RATE * TD)) == 0)
                        m_stb[i] = 1'b1;
                end
            end
            m_s2 = m_s1;
            m_s1 = bus.raw_i;
            m_cyc = m_cyc + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        chk("m_level", 32'(bus.level_o), 32'(m_lvl));
        chk("m_press", 32'(bus.press_o), 32'(m_press));
        chk("m_release", 32'(bus.release_o), 32'(m_rel));
        chk("m_strobe", 32'(bus.strobe_o), 32'(m_stb));
        chk("m_any", 32'(bus.any_active_o), 32'(|m_lvl));
    endtask

    task automatic step();
        @(negedge clk);
        check_model();
    endtask

    task automatic step_n(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    function automatic logic sig(input int ch, input int kind);
        case (kind)
            K_PRESS: return bus.press_o[ch];
            K_REL:   return bus.release_o[ch];
            default: return bus.strobe_o[ch];
        endcase
    endfunction

    task automatic wait_ev(input string tag, input int ch, input int kind,
                           input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            step();
            if (sig(ch, kind)) begin
                at = tcyc;
                break;
            end
        end
        chk(tag, 32'(at >= 0), 32'd1);
    endtask

    task automatic chk_window(input string tag, input int t, input int at);
        chk({tag, "_early"}, 32'(at >= t + 2 + (DEB - 1) * TD + 1), 32'd1);
        chk({tag, "_late"}, 32'(at <= t + 2 + DEB * TD), 32'd1);
    endtask

    int t, at, L, cnt, cnt2;
    int rep_q[$];
    int hold[N];

    initial begin
        bus.raw_i = 4'b1000;
        reset = 1'b1;
        step_n(3);
        chk("rst_level", 32'(bus.level_o), 32'd0);
        chk("rst_pulses", 32'(bus.press_o | bus.release_o | bus.strobe_o), 32'd0);
        chk("rst_any", 32'(bus.any_active_o), 32'd0);
        reset = 1'b0;

        // Active-low idle input must not press.
        step_n(20);
        chk("lvl3_idle", 32'(bus.level_o[3]), 32'd0);
        chk("any_idle", 32'(bus.any_active_o), 32'd0);

        // Clean press on a non-repeating channel.
        bus.raw_i[0] = 1'b1;
        t = tcyc;
        wait_ev("press0_wait", 0, K_PRESS, 30, at);
        chk_window("press0", t, at);
        chk("press0_level", 32'(bus.level_o[0]), 32'd1);
        chk("press0_strobe", 32'(bus.strobe_o[0]), 32'd1);
        step();
        chk("press0_width", 32'(bus.press_o[0]), 32'd0);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            cnt += int'(bus.strobe_o[0]);
        end
        chk("norepeat0", 32'(cnt), 32'd0);
        bus.raw_i[0] = 1'b0;
        step_n(20);

        // Bounce rejection.
        cnt = 0;
        for (int k = 0; k < 60; k++) begin
            if (k < 40 && (k % 3) == 0) bus.raw_i[0] = ~bus.raw_i[0];
            if (k == 40) bus.raw_i[0] = 1'b0;
            step();
            cnt += int'(bus.level_o[0]) + int'(bus.press_o[0]) +
                   int'(bus.release_o[0]) + int'(bus.strobe_o[0]);
        end
        chk("bounce0", 32'(cnt), 32'd0);

        // Auto-repeat on channel 1.
        bus.raw_i[1] = 1'b1;
        wait_ev("press1_wait", 1, K_PRESS, 30, L);
        rep_q = {};
        for (int k = 0; k < 40; k++) begin
            step();
            if (bus.strobe_o[1]) rep_q.push_back(tcyc - L);
        end
        chk("rep_count", 32'(rep_q.size()), 32'd3);
        if (rep_q.size() == 3) begin
            chk("rep_first", 32'(rep_q[0]), 32'd20);
            chk("rep_second", 32'(rep_q[1]), 32'd28);
            chk("rep_third", 32'(rep_q[2]), 32'd36);
        end
        bus.raw_i[1] = 1'b0;
        t = tcyc;
        wait_ev("rel1_wait", 1, K_REL, 30, at);
        chk_window("rel1", t, at);
        chk("rel1_nostrobe", 32'(bus.strobe_o[1]), 32'd0);
        cnt = 0; cnt2 = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            cnt += int'(bus.release_o[1]);
            cnt2 += int'(bus.strobe_o[1]);
        end
        chk("rel1_extra", 32'(cnt), 32'd0);
        chk("rel1_quiet", 32'(cnt2), 32'd0);

        // Active-low channel.
        bus.raw_i[3] = 1'b0;
        t = tcyc;
        wait_ev("press3_wait", 3, K_PRESS, 30, at);
        chk_window("press3", t, at);
        chk("press3_any", 32'(bus.any_active_o), 32'd1);
        bus.raw_i[3] = 1'b1;
        step_n(20);
        chk("lvl3_back", 32'(bus.level_o[3]), 32'd0);

        // Reset while repeating.
        bus.raw_i[1] = 1'b1;
        wait_ev("press1b_wait", 1, K_PRESS, 30, L);
        step_n(25);
        reset = 1'b1;
        step();
        chk("rstm_level", 32'(bus.level_o), 32'd0);
        chk("rstm_pulses", 32'(bus.press_o | bus.release_o | bus.strobe_o), 32'd0);
        chk("rstm_any", 32'(bus.any_active_o), 32'd0);
        reset = 1'b0;
        t = tcyc;
        wait_ev("press1c_wait", 1, K_PRESS, 30, at);
        chk_window("press1c", t, at);
        bus.raw_i[1] = 1'b0;
        step_n(40);

        // Simultaneous edges on two channels.
        bus.raw_i[1:0] = 2'b11;
        wait_ev("sim_wait", 0, K_PRESS, 30, at);
        chk("sim_press1", 32'(bus.press_o[1]), 32'd1);
        bus.raw_i[1:0] = 2'b00;
        step_n(40);

        // Random pin activity, one reset in the middle.
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    bus.raw_i[i] = 1'($urandom_range(0, 1));
                    hold[i] = int'($urandom_range(1, 25));
                end else begin
                    hold[i]--;
                end
            end
            reset = (k == 300);
            step();
        end
        reset = 1'b0;
        bus.raw_i = 4'b1000;
        step_n(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
